uart_cmd_parser: RTL and testbench

Byte-level command decoder sitting directly downstream of the UART receiver. It consumes each received byte (`rx_data` plus a one-cycle `rx_valid` strobe) and assembles ASCII command frames of the form `<letter><1..MAX_DIGITS decimal digits><CR|LF>`, for example `a0\r` or `b123\n`. It emits one decoded command (letter code plus binary value) per valid frame and flags malformed or stalled frames. Its outputs feed the plant-control logic.

---
 rtl/uart_cmd_parser_if.sv | 32 +++
 rtl/uart_cmd_parser.sv | 158 +++++++++++++++
 tb/tb_uart_cmd_parser.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_parser_if.sv
// rtl/uart_cmd_parser_if.sv - byte-in / command-out bundle for the UART command parser
//
// Signals:
//   rx_data   [7:0]          received byte, meaningful when rx_valid=1
//   rx_valid                 one-cycle strobe, new byte on rx_data
//   cmd_code  [7:0]          ASCII letter of the last good command
//   cmd_value [VALUE_W-1:0]  decoded value of the last good command
//   cmd_valid                one-cycle pulse, cmd_code/cmd_value updated
//   cmd_error                one-cycle pulse, frame rejected
//   busy                     frame in progress
// Modports: master = byte source / command sink, slave = parser.
interface uart_cmd_parser_if #(
    parameter int VALUE_W = 10
);
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic [7:0]         cmd_code;
    logic [VALUE_W-1:0] cmd_value;
    logic               cmd_valid;
    logic               cmd_error;
    logic               busy;

    modport master (
        output rx_data, rx_valid,
        input  cmd_code, cmd_value, cmd_valid, cmd_error, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd_code, cmd_value, cmd_valid, cmd_error, busy
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - ASCII <letter><digits><CR|LF> command frame decoder
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    uart_cmd_parser_if.slave: rx_data/rx_valid in; cmd_code, cmd_value,
//          cmd_valid, cmd_error, busy out (all outputs registered)
module uart_cmd_parser #(
    parameter int MAX_DIGITS     = 3,
    parameter int VALUE_W        = 10,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_cmd_parser_if.slave   bus
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIGITS,
        S_SKIP
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         letter_q, letter_d;
    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [7:0]         cmd_code_q, cmd_code_d;
    logic [VALUE_W-1:0] cmd_value_q, cmd_value_d;
    logic               cmd_valid_q, cmd_valid_d;
    logic               cmd_error_q, cmd_error_d;
    logic               busy_q;

    logic is_letter, is_digit, is_term;

    assign is_letter = (bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h7A);
    assign is_digit  = (bus.rx_data >= 8'h30) && (bus.rx_data <= 8'h39);
    assign is_term   = (bus.rx_data == 8'h0D) || (bus.rx_data == 8'h0A);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            letter_q    <= '0;
            acc_q       <= '0;
            count_q     <= '0;
            to_q        <= '0;
            cmd_code_q  <= '0;
            cmd_value_q <= '0;
            cmd_valid_q <= 1'b0;
            cmd_error_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            letter_q    <= letter_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            to_q        <= to_d;
            cmd_code_q  <= cmd_code_d;
            cmd_value_q <= cmd_value_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_error_q <= cmd_error_d;
            busy_q      <= (state_d != S_IDLE);
        end
    end

    always_comb begin
        state_d     = state_q;
        letter_d    = letter_q;
        acc_d       = acc_q;
        count_d     = count_q;
        cmd_code_d  = cmd_code_q;
        cmd_value_d = cmd_value_q;
        cmd_valid_d = 1'b0;
        cmd_error_d = 1'b0;
        // Idle counter clears on any byte and whenever not inside a frame;
        // it only advances in the frame states below.
        to_d        = '0;

        case (state_q)
            S_IDLE: begin
                if (bus.rx_valid) begin
                    if (is_letter) begin
                        letter_d = bus.rx_data;
                        acc_d    = '0;
                        count_d  = '0;
                        state_d  = S_DIGITS;
                    end else if (!is_term) begin
                        // Stray terminators are dropped so CR LF pairs pass silently.
                        cmd_error_d = 1'b1;
                    end
                end
            end

            S_DIGITS: begin
                if (bus.rx_valid) begin
                    if (is_digit) begin
                        if (count_q == MAX_CNT) begin
                            cmd_error_d = 1'b1;
                            state_d     = S_SKIP;
                        end else begin
                            // Widened multiply-add; VALUE_W holds 10^MAX_DIGITS-1 so
                            // the truncation back to VALUE_W never drops bits.
                            acc_d   = VALUE_W'((VALUE_W + 4)'(acc_q) * (VALUE_W + 4)'(10)
                                               + (VALUE_W + 4)'(bus.rx_data[3:0]));
                            count_d = count_q + CNT_W'(1);
                        end
                    end else if (is_term) begin
                        if (count_q != '0) begin
                            cmd_code_d  = letter_q;
                            cmd_value_d = acc_q;
                            cmd_valid_d = 1'b1;
                        end else begin
                            cmd_error_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        cmd_error_d = 1'b1;
                        state_d     = S_SKIP;
                    end
                end else if (to_q == TO_LAST) begin
                    cmd_error_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_SKIP: begin
                if (bus.rx_valid) begin
                    if (is_term) begin
                        state_d = S_IDLE;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.cmd_code  = cmd_code_q;
    assign bus.cmd_value = cmd_value_q;
    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_error = cmd_error_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// tb/tb_uart_cmd_parser.sv - directed self-checking bench for uart_cmd_parser
module tb_uart_cmd_parser;

    localparam int K_NONE = 0;
    localparam int K_VAL  = 1;
    localparam int K_ERR  = 2;
    localparam int TO     = 100;

    typedef struct {
        int         kind;
        logic [7:0] code;
        logic [9:0] value;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_cyc = 0;
    logic [7:0] good_code = 8'h00;
    logic [9:0] good_val  = 10'd0;
    exp_t q[$];

    uart_cmd_parser_if #(.VALUE_W(10)) bus ();

    uart_cmd_parser #(
        .MAX_DIGITS     (3),
        .VALUE_W        (10),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input int k, input logic [7:0] c, input logic [9:0] v, input int at);
        exp_t e;
        e.kind  = k;
        e.code  = c;
        e.value = v;
        e.cyc   = at;
        q.push_back(e);
    endtask

    // Drives one byte for exactly one cycle, starting at the current time
    // (always #1 after a rising edge) and returns #1 after the next edge.
    task automatic send(input logic [7:0] b, input int k, input logic [7:0] c, input int v);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        last_cyc     = cyc;
        if (k == K_VAL) begin
            good_code = c;
            good_val  = 10'(v);
            push_exp(K_VAL, c, 10'(v), cyc + 1);
        end else if (k == K_ERR) begin
            push_exp(K_ERR, good_code, good_val, cyc + 1);
        end
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard side: every pulse must match the oldest expectation, on the
    // exact cycle it was due, carrying the last good code/value.
    always @(negedge clk) begin
        if (rst_n) begin
            if (q.size() > 0 && q[0].cyc < cyc && !(bus.cmd_valid || bus.cmd_error)) begin
                checks++;
                errors++;
                $error("FAIL missing_pulse observed=none expected_kind=%0d at_cycle=%0d", q[0].kind, q[0].cyc);
                void'(q.pop_front());
            end
            if (bus.cmd_valid || bus.cmd_error) begin
                chk("valid_error_exclusive", 32'(bus.cmd_valid & bus.cmd_error), 32'd0);
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL unexpected_pulse observed=valid%0b/error%0b expected=none cycle=%0d",
                           bus.cmd_valid, bus.cmd_error, cyc);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("pulse_kind", bus.cmd_valid ? K_VAL : K_ERR, e.kind);
                    chk("pulse_cycle", cyc, e.cyc);
                    chk("cmd_code", 32'(bus.cmd_code), 32'(e.code));
                    chk("cmd_value", 32'(bus.cmd_value), 32'(e.value));
                end
            end
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        idle(3);
        chk("rst_code", 32'(bus.cmd_code), 32'd0);
        chk("rst_value", 32'(bus.cmd_value), 32'd0);
        chk("rst_valid", 32'(bus.cmd_valid), 32'd0);
        chk("rst_error", 32'(bus.cmd_error), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // a0\r with gaps
        send(8'h61, K_NONE, 8'h00, 0);
        chk("busy_after_letter", 32'(bus.busy), 32'd1);
        idle(20);
        send(8'h30, K_NONE, 8'h00, 0);
        idle(20);
        send(8'h0D, K_VAL, 8'h61, 0);
        chk("busy_after_term", 32'(bus.busy), 32'd0);
        idle(20);

        // b123\r\n back-to-back
        send(8'h62, K_NONE, 8'h00, 0);
        send(8'h31, K_NONE, 8'h00, 0);
        send(8'h32, K_NONE, 8'h00, 0);
        send(8'h33, K_NONE, 8'h00, 0);
        send(8'h0D, K_VAL, 8'h62, 123);
        send(8'h0A, K_NONE, 8'h00, 0);
        idle(4);

        // a1234\r (overflow) then c7\n
        send(8'h61, K_NONE, 8'h00, 0);
        send(8'h31, K_NONE, 8'h00, 0);
        send(8'h32, K_NONE, 8'h00, 0);
        send(8'h33, K_NONE, 8'h00, 0);
        send(8'h34, K_ERR, 8'h00, 0);
        chk("busy_in_skip", 32'(bus.busy), 32'd1);
        send(8'h0D, K_NONE, 8'h00, 0);
        send(8'h63, K_NONE, 8'h00, 0);
        send(8'h37, K_NONE, 8'h00, 0);
        send(8'h0A, K_VAL, 8'h63, 7);
        idle(3);

        // largest value z999\r
        send(8'h7A, K_NONE, 8'h00, 0);
        send(8'h39, K_NONE, 8'h00, 0);
        send(8'h39, K_NONE, 8'h00, 0);
        send(8'h39, K_NONE, 8'h00, 0);
        send(8'h0D, K_VAL, 8'h7A, 999);
        idle(3);

        // a\r, lone '5', '!' in IDLE
        send(8'h61, K_NONE, 8'h00, 0);
        send(8'h0D, K_ERR, 8'h00, 0);
        send(8'h35, K_ERR, 8'h00, 0);
        send(8'h21, K_ERR, 8'h00, 0);
        idle(3);

        // letter then other inside DIGITS -> SKIP, terminator silent
        send(8'h62, K_NONE, 8'h00, 0);
        send(8'h31, K_NONE, 8'h00, 0);
        send(8'h41, K_ERR, 8'h00, 0);
        send(8'h0A, K_NONE, 8'h00, 0);
        idle(3);

        // timeout in DIGITS: a4 then silence
        send(8'h61, K_NONE, 8'h00, 0);
        send(8'h34, K_NONE, 8'h00, 0);
        push_exp(K_ERR, good_code, good_val, last_cyc + TO + 1);
        idle(TO - 1);
        chk("busy_before_timeout", 32'(bus.busy), 32'd1);
        idle(1);
        chk("busy_after_timeout", 32'(bus.busy), 32'd0);
        idle(3);

        // byte arriving on the expiry cycle wins
        send(8'h61, K_NONE, 8'h00, 0);
        send(8'h34, K_NONE, 8'h00, 0);
        idle(TO - 1);
        send(8'h35, K_NONE, 8'h00, 0);
        chk("busy_after_late_byte", 32'(bus.busy), 32'd1);
        send(8'h0D, K_VAL, 8'h61, 45);
        idle(3);

        // reset mid-frame
        send(8'h64, K_NONE, 8'h00, 0);
        send(8'h39, K_NONE, 8'h00, 0);
        rst_n = 1'b0;
        #1;
        chk("busy_in_reset", 32'(bus.busy), 32'd0);
        idle(2);
        chk("code_after_reset", 32'(bus.cmd_code), 32'd0);
        chk("value_after_reset", 32'(bus.cmd_value), 32'd0);
        chk("valid_in_reset", 32'(bus.cmd_valid), 32'd0);
        chk("error_in_reset", 32'(bus.cmd_error), 32'd0);
        good_code = 8'h00;
        good_val  = 10'd0;
        rst_n = 1'b1;
        idle(1);
        send(8'h65, K_NONE, 8'h00, 0);
        send(8'h35, K_NONE, 8'h00, 0);
        send(8'h0D, K_VAL, 8'h65, 5);
        idle(5);

        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
